mem_access: RTL and testbench

//  Memory-access (MA) stage of the single-clock MIPS datapath. Holds the word-organised

---
 rtl/mem_access.sv | 100 ++++++++++
 tb/tb_mem_access.sv | 133 +++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// rtl/mem_access.sv - MIPS memory-access stage: word data memory and write-back mux.
// Optional sub-word loads/stores (LB/LH/LBU/LHU/SB/SH) enabled by macro MA_BYTE_ACCESS_EN.
module mem_access #(
    parameter int DM_AW  = 8,
    parameter int OP_LW  = 35,
    parameter int OP_SW  = 43,
    parameter int OP_JAL = 3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] Result,
    input  logic [31:0] Rdata2,
    input  logic [31:0] nextPC,
    input  logic [31:0] Ins,
    output logic [31:0] Wdata
);
    localparam int DEPTH = 1 << DM_AW;
    localparam logic [5:0] OP_LW_C  = 6'(OP_LW);
    localparam logic [5:0] OP_SW_C  = 6'(OP_SW);
    localparam logic [5:0] OP_JAL_C = 6'(OP_JAL);
`ifdef MA_BYTE_ACCESS_EN
    localparam logic [5:0] OP_LB  = 6'd32;
    localparam logic [5:0] OP_LH  = 6'd33;
    localparam logic [5:0] OP_LBU = 6'd36;
    localparam logic [5:0] OP_LHU = 6'd37;
    localparam logic [5:0] OP_SB  = 6'd40;
    localparam logic [5:0] OP_SH  = 6'd41;
`endif

    logic [31:0]      dm_q [DEPTH];
    logic [5:0]       op;
    logic [DM_AW-1:0] idx;
    logic [31:0]      word_rd;
    logic             wr_en;
    logic [31:0]      wr_data;
    logic             unused_ok;

    assign op        = Ins[31:26];
    assign idx       = Result[DM_AW+1:2];
    assign word_rd   = dm_q[idx];
    assign unused_ok = ^{Ins[25:0], Result[31:DM_AW+2], Result[1:0]};

    // Sub-word stores are read-modify-write of the addressed word in one edge.
    always_comb begin
        wr_en   = 1'b0;
        wr_data = word_rd;
        if (op == OP_SW_C) begin
            wr_en   = 1'b1;
            wr_data = Rdata2;
        end
`ifdef MA_BYTE_ACCESS_EN
        else if (op == OP_SB) begin
            wr_en = 1'b1;
            wr_data[{Result[1:0], 3'b000} +: 8] = Rdata2[7:0];
        end else if (op == OP_SH) begin
            wr_en = 1'b1;
            wr_data[{Result[1], 4'b0000} +: 16] = Rdata2[15:0];
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                dm_q[i] <= '0;
            end
        end else if (wr_en) begin
            dm_q[idx] <= wr_data;
        end
    end

`ifdef MA_BYTE_ACCESS_EN
    logic [7:0]  byte_rd;
    logic [15:0] half_rd;
    assign byte_rd = word_rd[{Result[1:0], 3'b000} +: 8];
    assign half_rd = word_rd[{Result[1], 4'b0000} +: 16];
`endif

    always_comb begin
        Wdata = Result;
        if (!RST) begin
            Wdata = '0;
        end else if (op == OP_LW_C) begin
            Wdata = word_rd;
        end else if (op == OP_JAL_C) begin
            Wdata = nextPC;
        end
`ifdef MA_BYTE_ACCESS_EN
        else if (op == OP_LB) begin
            Wdata = {{24{byte_rd[7]}}, byte_rd};
        end else if (op == OP_LBU) begin
            Wdata = {24'd0, byte_rd};
        end else if (op == OP_LH) begin
            Wdata = {{16{half_rd[15]}}, half_rd};
        end else if (op == OP_LHU) begin
            Wdata = {16'd0, half_rd};
        end
`endif
    end
endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - directed and randomized checks of mem_access against a behavioural model.
module tb_mem_access;
    logic        CLK;
    logic        RST;
    logic [31:0] Result;
    logic [31:0] Rdata2;
    logic [31:0] nextPC;
    logic [31:0] Ins;
    logic [31:0] Wdata;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] mem [256];

    mem_access dut (
        .CLK(CLK), .RST(RST), .Result(Result), .Rdata2(Rdata2),
        .nextPC(nextPC), .Ins(Ins), .Wdata(Wdata)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] model_w(bit rst, int op, logic [31:0] res, logic [31:0] nxt);
        logic [31:0] w;
        int unsigned sh;
        int unsigned b;
        int unsigned h;
        w  = mem[res[9:2]];
        sh = 8 * res[1:0];
        b  = (w >> sh) & 32'hFF;
        h  = (w >> (16 * res[1])) & 32'hFFFF;
        if (!rst) return 32'h0;
        case (op)
            35: return w;
            3:  return nxt;
`ifdef MA_BYTE_ACCESS_EN
            32: return (b >= 128) ? (32'hFFFFFF00 | b) : b;
            36: return b;
            33: return (h >= 32768) ? (32'hFFFF0000 | h) : h;
            37: return h;
`endif
            default: return res;
        endcase
    endfunction

    task automatic model_edge(bit rst, int op, logic [31:0] res, logic [31:0] d);
        logic [31:0] mask;
        int unsigned sh;
        if (!rst) begin
            for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        end else if (op == 43) begin
            mem[res[9:2]] = d;
        end
`ifdef MA_BYTE_ACCESS_EN
        else if (op == 40 || op == 41) begin
            sh   = (op == 40) ? 8 * res[1:0] : 16 * res[1];
            mask = ((op == 40) ? 32'hFF : 32'hFFFF) << sh;
            mem[res[9:2]] = (mem[res[9:2]] & ~mask) | ((d << sh) & mask);
        end
`endif
    endtask

    task automatic check(string tag, logic [31:0] exp);
        n_cmp++;
        assert (Wdata === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, Wdata, exp);
        end
    endtask

    // Drive one instruction, check Wdata before the edge, then let the edge commit it.
    task automatic step(string tag, bit rst, int op, logic [31:0] res, logic [31:0] d,
                        logic [31:0] nxt, logic [31:0] exp_dir, bit use_dir);
        logic [31:0] lo;
        lo = $urandom();
        @(negedge CLK);
        RST    = rst;
        Ins    = {op[5:0], lo[25:0]};
        Result = res;
        Rdata2 = d;
        nextPC = nxt;
        #1;
        check(tag, use_dir ? exp_dir : model_w(rst, op, res, nxt));
        model_edge(rst, op, res, d);
    endtask

    initial begin
        int ops [8] = '{0, 35, 43, 3, 8, 4, 35, 43};
        RST = 1'b0; Ins = '0; Result = '0; Rdata2 = '0; nextPC = '0;
        step("reset_wdata", 0, 35, 32'h20, 32'h0, 32'h0, 32'h0, 1);
        step("reset_sw_blocked", 0, 43, 32'h20, 32'h1234, 32'h0, 32'h0, 1);
        step("lw_cleared", 1, 35, 32'h20, 32'h0, 32'h0, 32'h0, 1);
        step("sw_word", 1, 43, 32'h20, 32'hDEADBEEF, 32'h0, 32'h20, 1);
        step("lw_after_sw", 1, 35, 32'h20, 32'h0, 32'h0, 32'hDEADBEEF, 1);
        step("rtype", 1, 0, 32'h12345678, 32'hFFFFFFFF, 32'h0, 32'h12345678, 1);
        step("lw_unchanged", 1, 35, 32'h20, 32'h0, 32'h0, 32'hDEADBEEF, 1);
        step("jal", 1, 3, 32'h55, 32'h0, 32'h00400008, 32'h00400008, 1);
        step("unknown_op", 1, 63, 32'h20, 32'h77777777, 32'h0, 32'h20, 1);
        step("lw_no_unk_wr", 1, 35, 32'h20, 32'h0, 32'h0, 32'hDEADBEEF, 1);
        step("sw_wrap", 1, 43, 32'h421, 32'hA5A5A5A5, 32'h0, 32'h421, 1);
        step("lw_wrap", 1, 35, 32'h20, 32'h0, 32'h0, 32'hA5A5A5A5, 1);
        step("lw_depth_top", 1, 35, 32'h3FC, 32'h0, 32'h0, 32'h0, 1);
        step("sw_depth_top", 1, 43, 32'hFFFF_FFFF, 32'hCAFEF00D, 32'h0, 32'hFFFFFFFF, 1);
        step("lw_depth_top2", 1, 35, 32'h3FC, 32'h0, 32'h0, 32'hCAFEF00D, 1);
`ifdef MA_BYTE_ACCESS_EN
        step("b_sw", 1, 43, 32'h20, 32'hDEADBEEF, 32'h0, 32'h20, 1);
        step("b_sb", 1, 40, 32'h21, 32'h11, 32'h0, 32'h21, 1);
        step("b_lw", 1, 35, 32'h20, 32'h0, 32'h0, 32'hDEADBEEF & 32'hFFFF00FF | 32'h1100, 1);
        step("b_lb", 1, 32, 32'h23, 32'h0, 32'h0, 32'hFFFFFFDE, 1);
        step("b_lbu", 1, 36, 32'h23, 32'h0, 32'h0, 32'h000000DE, 1);
        step("b_lh", 1, 33, 32'h22, 32'h0, 32'h0, 32'hFFFFDEAD, 1);
        step("b_lhu_mis", 1, 37, 32'h23, 32'h0, 32'h0, 32'h0000DEAD, 1);
`endif
        step("reset_again", 0, 0, 32'h99, 32'h0, 32'h0, 32'h0, 1);
        step("lw_after_rst", 1, 35, 32'h3FC, 32'h0, 32'h0, 32'h0, 1);
        for (int i = 0; i < 400; i++) begin
            int op;
            logic [31:0] res;
            logic [31:0] d;
            logic [31:0] nxt;
            bit rst;
            res = $urandom();
            res[9:2] = 8'($urandom_range(0, 15));
            d   = $urandom();
            nxt = $urandom();
            op  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : ops[$urandom_range(0, 7)];
            rst = ($urandom_range(0, 59) != 0);
            step("random", rst, op, res, d, nxt, 32'h0, 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
